ysyx_23060025_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_23060025_mem_arbiter
// PURPOSE
//  Shares one downstream memory port between the icache refill port (read-only bursts) and the LSU data port
//  (single-beat read/write). Sits between the cpu core and the SoC bus bridge.
//  Round-robin arbitration, one outstanding transaction, burst beat checking, stall watchdog.
// PARAMETERS
//  ADDR_LEN        32    address width
//  DATA_LEN        32    data width
//  TIMEOUT_CYCLES  1024  grant cycles without m_pvalid before err_o sets; must be >= 2
// PORTS
//  clock     in   1         clock, rising edge
//  reset     in   1         synchronous, active-high
//  i_paddr   in   ADDR_LEN  icache burst start address
//  i_psel    in   1         icache request; held until its last beat
//  i_plen    in   8         icache beats minus 1
//  i_psize   in   3         icache beat size (log2 bytes)
//  i_prdata  out  DATA_LEN  icache read data
//  i_pvalid  out  1         icache beat valid
//  i_plast   out  1         icache last beat
//  d_paddr   in   ADDR_LEN  LSU address
//  d_psel    in   1         LSU request; held until d_pvalid
//  d_pwrite  in   1         1=write, 0=read
//  d_psize   in   3         LSU access size
//  d_pwdata  in   DATA_LEN  LSU write data
//  d_pwstrb  in   4         LSU byte strobes
//  d_prdata  out  DATA_LEN  LSU read data
//  d_pvalid  out  1         LSU response valid (read data or write ack)
//  m_paddr   out  ADDR_LEN  downstream address
//  m_psel    out  1         downstream request
//  m_pwrite  out  1         downstream write
//  m_plen    out  8         downstream beats minus 1 (0 for LSU)
//  m_psize   out  3         downstream size
//  m_pwdata  out  DATA_LEN  downstream write data
//  m_pwstrb  out  4         downstream strobes (0 for icache)
//  m_prdata  in   DATA_LEN  downstream read data
//  m_pvalid  in   1         downstream beat / write ack valid
//  m_plast   in   1         downstream last beat
//  grant_o   out  2         debug: 00 idle, 01 icache, 10 LSU
//  err_o     out  1         sticky protocol/timeout error
// BEHAVIOUR
//  States: IDLE, GNT_I, GNT_D; state reg is the only grant source.
//  IDLE: i_psel only -> GNT_I; d_psel only -> GNT_D; both -> requester not in last_gnt.
//   last_gnt resets to I, so the LSU wins the first tie. It updates on every grant.
//  Latency: request seen in IDLE -> m_psel=1 next cycle. m_psel = (state!=IDLE), registered, not passthrough.
//  GNT_I: m_* muxed combinationally from i_* (m_pwrite=0, m_pwstrb=0).
//   i_pvalid=m_pvalid, i_plast=m_plast, i_prdata=m_prdata.
//   Exits to IDLE on m_pvalid&m_plast.
//  GNT_D: m_* muxed from d_* (m_plen=0). d_pvalid=m_pvalid, d_prdata=m_prdata.
//   Exits to IDLE on m_pvalid; m_plast is ignored.
//  Non-granted pvalid is always 0. IDLE drives all m_* to 0.
//  One IDLE bubble always separates back-to-back transactions.
//  Beat counter (8b): clears on grant, increments on m_pvalid in GNT_I. Sets err_o if:
//   - m_plast arrives with count!=m_plen, or
//   - m_pvalid arrives with count==m_plen and m_plast=0.
//  On err, the FSM still exits only on m_plast.
//  Watchdog: counter clears on grant and on m_pvalid, increments in GNT_*.
//   Sets err_o at TIMEOUT_CYCLES. No abort; grant is held.
//  Granted requester dropping psel mid-transaction: ignored; grant held until completion.
//  m_pvalid while IDLE: dropped, err_o set.
//  Reset, including mid-transaction: state IDLE, last_gnt=I, counters 0, err_o=0, all outputs 0.
// TESTING
//  - i_psel=1, i_plen=3, 4 beats with m_plast on beat 4 -> i_pvalid x4, i_plast on beat 4, IDLE after, err_o=0.
//  - i_psel and d_psel rise in the same cycle after reset -> GNT_D first, m_psel at +1, then IDLE bubble, then GNT_I.
//  - d_pwrite=1, d_paddr=0x8000_0010, d_pwstrb=4'b0011 -> m_* match, m_plen=0; d_pvalid on ack, i_pvalid stays 0.
//  - i_plen=3, m_plast on beat 2 -> err_o=1 and stays 1 until reset.
//  - GNT_D with no m_pvalid for TIMEOUT_CYCLES -> err_o=1, grant_o stays 10; late m_pvalid -> IDLE.
//  - reset asserted during beat 2 of a 4-beat burst -> next cycle: all outputs 0, grant_o=00, new request accepted.

Source files
------------

// File: rtl/ysyx_23060025_mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between the icache
// refill port (read bursts) and the LSU port (single beats), with beat and stall checks.
module ysyx_23060025_mem_arbiter #(
  parameter int ADDR_LEN       = 32,
  parameter int DATA_LEN       = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] i_paddr,
  input  logic                i_psel,
  input  logic [7:0]          i_plen,
  input  logic [2:0]          i_psize,
  output logic [DATA_LEN-1:0] i_prdata,
  output logic                i_pvalid,
  output logic                i_plast,
  input  logic [ADDR_LEN-1:0] d_paddr,
  input  logic                d_psel,
  input  logic                d_pwrite,
  input  logic [2:0]          d_psize,
  input  logic [DATA_LEN-1:0] d_pwdata,
  input  logic [3:0]          d_pwstrb,
  output logic [DATA_LEN-1:0] d_prdata,
  output logic                d_pvalid,
  output logic [ADDR_LEN-1:0] m_paddr,
  output logic                m_psel,
  output logic                m_pwrite,
  output logic [7:0]          m_plen,
  output logic [2:0]          m_psize,
  output logic [DATA_LEN-1:0] m_pwdata,
  output logic [3:0]          m_pwstrb,
  input  logic [DATA_LEN-1:0] m_prdata,
  input  logic                m_pvalid,
  input  logic                m_plast,
  output logic [1:0]          grant_o,
  output logic                err_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Encoding doubles as the debug grant code.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_I = 2'b01,
    ST_GNT_D = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;   // 0: icache, 1: LSU
  logic [7:0]      beat_q, beat_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    beat_d     = beat_q;
    wd_d       = wd_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (m_pvalid) err_d = 1'b1;
        if (i_psel && d_psel) begin
          state_d = last_gnt_q ? ST_GNT_I : ST_GNT_D;
        end else if (i_psel) begin
          state_d = ST_GNT_I;
        end else if (d_psel) begin
          state_d = ST_GNT_D;
        end
        if (state_d != ST_IDLE) begin
          last_gnt_d = (state_d == ST_GNT_D);
          beat_d     = 8'd0;
          wd_d       = '0;
        end
      end
      ST_GNT_I: begin
        if (m_pvalid) begin
          beat_d = beat_q + 8'd1;
          wd_d   = '0;
          if (m_plast && (beat_q != i_plen)) err_d = 1'b1;
          if (!m_plast && (beat_q == i_plen)) err_d = 1'b1;
          if (m_plast) state_d = ST_IDLE;
        end else if (wd_q == WD_LAST) begin
          err_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_GNT_D: begin
        // A single-beat access completes on any m_pvalid; m_plast is irrelevant.
        if (m_pvalid) begin
          wd_d    = '0;
          state_d = ST_IDLE;
        end else if (wd_q == WD_LAST) begin
          err_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b0;
      beat_q     <= 8'd0;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      beat_q     <= beat_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    m_paddr  = '0;
    m_pwrite = 1'b0;
    m_plen   = 8'd0;
    m_psize  = 3'd0;
    m_pwdata = '0;
    m_pwstrb = 4'd0;
    i_prdata = '0;
    i_pvalid = 1'b0;
    i_plast  = 1'b0;
    d_prdata = '0;
    d_pvalid = 1'b0;
    case (state_q)
      ST_GNT_I: begin
        m_paddr  = i_paddr;
        m_plen   = i_plen;
        m_psize  = i_psize;
        i_prdata = m_prdata;
        i_pvalid = m_pvalid;
        i_plast  = m_plast;
      end
      ST_GNT_D: begin
        m_paddr  = d_paddr;
        m_pwrite = d_pwrite;
        m_psize  = d_psize;
        m_pwdata = d_pwdata;
        m_pwstrb = d_pwstrb;
        d_prdata = m_prdata;
        d_pvalid = m_pvalid;
      end
      default: ;
    endcase
  end

  assign m_psel  = (state_q != ST_IDLE);
  assign grant_o = state_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_ysyx_23060025_mem_arbiter.sv
// Bench for ysyx_23060025_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_ysyx_23060025_mem_arbiter;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] i_paddr, d_paddr, d_pwdata, m_prdata;
  logic        i_psel, d_psel, d_pwrite, m_pvalid, m_plast;
  logic [7:0]  i_plen;
  logic [2:0]  i_psize, d_psize;
  logic [3:0]  d_pwstrb;
  logic [31:0] i_prdata, d_prdata, m_paddr, m_pwdata;
  logic        i_pvalid, i_plast, d_pvalid, m_psel, m_pwrite, err_o;
  logic [7:0]  m_plen;
  logic [2:0]  m_psize;
  logic [3:0]  m_pwstrb;
  logic [1:0]  grant_o;

  int vec_n = 0;
  int miss_n = 0;

  // Model: owner 0 none / 1 icache / 2 LSU, last winner, beat index, stall run, sticky error.
  int owner = 0, last_g = 1, beats = 0, stall = 0;
  bit err_m = 1'b0;

  ysyx_23060025_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .i_paddr(i_paddr), .i_psel(i_psel), .i_plen(i_plen), .i_psize(i_psize),
    .i_prdata(i_prdata), .i_pvalid(i_pvalid), .i_plast(i_plast),
    .d_paddr(d_paddr), .d_psel(d_psel), .d_pwrite(d_pwrite), .d_psize(d_psize),
    .d_pwdata(d_pwdata), .d_pwstrb(d_pwstrb), .d_prdata(d_prdata), .d_pvalid(d_pvalid),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_pwrite(m_pwrite), .m_plen(m_plen),
    .m_psize(m_psize), .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb),
    .m_prdata(m_prdata), .m_pvalid(m_pvalid), .m_plast(m_plast),
    .grant_o(grant_o), .err_o(err_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      owner = 0; last_g = 1; beats = 0; stall = 0; err_m = 1'b0;
    end else if (owner == 0) begin
      if (m_pvalid) err_m = 1'b1;
      if (i_psel && d_psel) owner = (last_g == 1) ? 2 : 1;
      else if (i_psel) owner = 1;
      else if (d_psel) owner = 2;
      if (owner != 0) begin
        last_g = owner; beats = 0; stall = 0;
      end
    end else if (m_pvalid) begin
      if (owner == 1) begin
        if (m_plast && beats != int'(i_plen)) err_m = 1'b1;
        if (!m_plast && beats == int'(i_plen)) err_m = 1'b1;
        beats = (beats + 1) % 256;
      end
      stall = 0;
      if (owner == 2 || m_plast) owner = 0;
    end else begin
      stall++;
      if (stall >= TO) err_m = 1'b1;
    end
  endtask

  task automatic compare_all();
    bit gi, gd;
    gi = (owner == 1);
    gd = (owner == 2);
    chk("grant_o",  grant_o,  64'(owner));
    chk("m_psel",   m_psel,   64'(owner != 0));
    chk("m_paddr",  m_paddr,  gi ? i_paddr : (gd ? d_paddr : 32'd0));
    chk("m_pwrite", m_pwrite, gd ? d_pwrite : 1'b0);
    chk("m_plen",   m_plen,   gi ? i_plen : 8'd0);
    chk("m_psize",  m_psize,  gi ? i_psize : (gd ? d_psize : 3'd0));
    chk("m_pwdata", m_pwdata, gd ? d_pwdata : 32'd0);
    chk("m_pwstrb", m_pwstrb, gd ? d_pwstrb : 4'd0);
    chk("i_pvalid", i_pvalid, 64'(gi && m_pvalid));
    chk("i_plast",  i_plast,  64'(gi && m_plast));
    chk("i_prdata", i_prdata, gi ? m_prdata : 32'd0);
    chk("d_pvalid", d_pvalid, 64'(gd && m_pvalid));
    chk("d_prdata", d_prdata, gd ? m_prdata : 32'd0);
    chk("err_o",    err_o,    64'(err_m));
  endtask

  // Inputs are set just after the falling edge; settle() checks, adv() clocks.
  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic adv();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; i_psel = 1'b0; d_psel = 1'b0; m_pvalid = 1'b0; m_plast = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_paddr = 0; i_psel = 0; i_plen = 0; i_psize = 0;
    d_paddr = 0; d_psel = 0; d_pwrite = 0; d_psize = 0; d_pwdata = 0; d_pwstrb = 0;
    m_prdata = 0; m_pvalid = 0; m_plast = 0;
    @(posedge clock);
    model_update();
    @(negedge clock);
    do_reset();

    settle();
    chk("lit_reset_grant", grant_o, 2'b00);
    chk("lit_reset_psel", m_psel, 1'b0);
    chk("lit_reset_err", err_o, 1'b0);

    // Clean 4-beat icache burst.
    i_psel = 1'b1; i_plen = 8'd3; i_paddr = 32'h0000_1000; i_psize = 3'd2;
    tick();
    settle();
    chk("lit_burst_grant", grant_o, 2'b01);
    chk("lit_burst_plen", m_plen, 8'd3);
    chk("lit_burst_addr", m_paddr, 32'h0000_1000);
    for (int b = 0; b < 4; b++) begin
      m_pvalid = 1'b1; m_plast = (b == 3); m_prdata = 32'hA0 + 32'(b);
      settle();
      chk("lit_burst_ivalid", i_pvalid, 1'b1);
      chk("lit_burst_ilast", i_plast, 64'(b == 3));
      chk("lit_burst_rdata", i_prdata, 32'hA0 + 32'(b));
      adv();
    end
    idle_inputs();
    settle();
    chk("lit_burst_idle", grant_o, 2'b00);
    chk("lit_burst_err", err_o, 1'b0);
    adv();

    // Simultaneous requests after reset: LSU first, bubble, then icache.
    do_reset();
    i_psel = 1'b1; i_plen = 8'd0; d_psel = 1'b1; d_pwrite = 1'b0; d_paddr = 32'h44;
    tick();
    settle();
    chk("lit_tie_grant_d", grant_o, 2'b10);
    chk("lit_tie_psel", m_psel, 1'b1);
    m_pvalid = 1'b1; m_prdata = 32'h1234_5678;
    settle();
    chk("lit_tie_dvalid", d_pvalid, 1'b1);
    chk("lit_tie_ivalid", i_pvalid, 1'b0);
    adv();
    m_pvalid = 1'b0; d_psel = 1'b0;
    settle();
    chk("lit_tie_bubble", grant_o, 2'b00);
    adv();
    settle();
    chk("lit_tie_grant_i", grant_o, 2'b01);
    m_pvalid = 1'b1; m_plast = 1'b1;
    tick();
    idle_inputs();
    tick();

    // LSU write passthrough.
    d_psel = 1'b1; d_pwrite = 1'b1; d_paddr = 32'h8000_0010; d_pwstrb = 4'b0011;
    d_pwdata = 32'hDEAD_BEEF; d_psize = 3'd1;
    tick();
    settle();
    chk("lit_wr_addr", m_paddr, 32'h8000_0010);
    chk("lit_wr_write", m_pwrite, 1'b1);
    chk("lit_wr_strb", m_pwstrb, 4'b0011);
    chk("lit_wr_plen", m_plen, 8'd0);
    chk("lit_wr_data", m_pwdata, 32'hDEAD_BEEF);
    m_pvalid = 1'b1;
    settle();
    chk("lit_wr_ack", d_pvalid, 1'b1);
    chk("lit_wr_ivalid", i_pvalid, 1'b0);
    adv();
    idle_inputs();
    tick();

    // Early m_plast on beat 2 of a 4-beat burst: sticky error.
    i_psel = 1'b1; i_plen = 8'd3;
    tick();
    m_pvalid = 1'b1; m_plast = 1'b0;
    tick();
    m_plast = 1'b1;
    tick();
    idle_inputs();
    settle();
    chk("lit_early_err", err_o, 1'b1);
    chk("lit_early_idle", grant_o, 2'b00);
    adv();
    tick();
    settle();
    chk("lit_early_sticky", err_o, 1'b1);
    adv();
    do_reset();
    settle();
    chk("lit_early_cleared", err_o, 1'b0);

    // LSU stall watchdog.
    d_psel = 1'b1; d_pwrite = 1'b0;
    tick();
    for (int k = 0; k < TO; k++) begin
      settle();
      chk("lit_wd_noerr", err_o, 1'b0);
      adv();
    end
    settle();
    chk("lit_wd_err", err_o, 1'b1);
    chk("lit_wd_grant", grant_o, 2'b10);
    m_pvalid = 1'b1;
    tick();
    idle_inputs();
    settle();
    chk("lit_wd_idle", grant_o, 2'b00);
    adv();

    // Reset during beat 2 of a 4-beat burst.
    do_reset();
    i_psel = 1'b1; i_plen = 8'd3;
    tick();
    m_pvalid = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; m_pvalid = 1'b0; m_plast = 1'b0;
    settle();
    chk("lit_rst_grant", grant_o, 2'b00);
    chk("lit_rst_psel", m_psel, 1'b0);
    chk("lit_rst_ivalid", i_pvalid, 1'b0);
    chk("lit_rst_err", err_o, 1'b0);
    adv();
    settle();
    chk("lit_rst_regrant", grant_o, 2'b01);
    adv();

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (owner == 1) begin
        i_psel = ($urandom_range(0, 15) != 0);
      end else begin
        i_psel = ($urandom_range(0, 2) == 0);
        i_paddr = $urandom; i_plen = 8'($urandom_range(0, 3)); i_psize = 3'($urandom);
      end
      if (owner == 2) begin
        d_psel = ($urandom_range(0, 15) != 0);
      end else begin
        d_psel = ($urandom_range(0, 2) == 0);
        d_paddr = $urandom; d_pwrite = 1'($urandom); d_psize = 3'($urandom);
        d_pwdata = $urandom; d_pwstrb = 4'($urandom);
      end
      m_prdata = $urandom;
      if (owner == 1) begin
        m_pvalid = ($urandom_range(0, 2) != 0);
        m_plast = (beats == int'(i_plen)) ^ ($urandom_range(0, 19) == 0);
      end else if (owner == 2) begin
        m_pvalid = ($urandom_range(0, 3) == 0);
        m_plast = 1'($urandom);
      end else begin
        m_pvalid = ($urandom_range(0, 63) == 0);
        m_plast = 1'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end
endmodule
